// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams a little-endian byte image into a 32-bit instruction
//               memory, one word per write pulse, then releases the core
//               from reset once the whole image has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_rst
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counters are AW+1 bits so a full DEPTH-word image never wraps
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    state_t          r_state;
    state_t          w_next;
    logic [AW:0]     r_len;
    logic [AW:0]     r_wcnt;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_asm;
    logic [AW-1:0]   r_waddr;
    logic [31:0]     r_wdata;
    logic            r_err;

    logic            w_start_ok;
    logic            w_accept;
    logic            w_last;

    assign w_start_ok = start && (len != '0) && (len <= c_depth);
    assign w_accept   = (r_state == S_LOAD) && byte_valid;
    assign w_last     = (r_wcnt == (r_len - 1'b1));

    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign err   = r_err;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        core_rst   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_start_ok ? S_LOAD : S_IDLE;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && (r_bcnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                we     = 1'b1;
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b1;
                if (start) begin
                    w_next = w_start_ok ? S_LOAD : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: start handling, byte assembly, word counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len   <= '0;
            r_wcnt  <= '0;
            r_bcnt  <= 2'd0;
            r_asm   <= 24'd0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_len  <= len;
                            r_wcnt <= '0;
                            r_bcnt <= 2'd0;
                            r_err  <= 1'b0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        case (r_bcnt)
                            2'd0: r_asm[7:0]   <= byte_data;
                            2'd1: r_asm[15:8]  <= byte_data;
                            2'd2: r_asm[23:16] <= byte_data;
                            default: begin
                                // Final byte completes the word; present it for the write cycle
                                r_wdata <= {byte_data, r_asm};
                                r_waddr <= r_wcnt[AW-1:0];
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in the target instruction memory.
REQ-002 SHALL have parameter AW, default 10, meaning word-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a load, sampled on rising edge.
REQ-006 SHALL have port len  input  AW+1  number of words to load, sampled with start.
REQ-007 SHALL have port byte_valid  input  1  source offers byte_data.
REQ-008 SHALL have port byte_data  input  8  incoming image byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port we  output  1  instruction-memory write enable.
REQ-011 SHALL have port waddr  output  AW  word index (memory byte address A = waddr*4).
REQ-012 SHALL have port wdata  output  32  assembled instruction word.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  image complete.
REQ-015 SHALL have port err  output  1  last start was rejected.
REQ-016 SHALL have port core_rst  output  1  active-low reset to the core; 0 holds the core in reset.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start=1 with 1<=len<=DEPTH SHALL latch len, clear word/byte counters and err, and enter LOAD next cycle.
REQ-019 IDLE or DONE: start=1 with len=0 or len>DEPTH SHALL set err=1, go/stay IDLE, and not write; err SHALL hold until the next start.
REQ-020 byte_ready SHALL be 1 exactly in LOAD; a byte is accepted on an edge where byte_valid=1 and byte_ready=1.
REQ-021 Bytes SHALL be little-endian: byte k (k=0..3) of a word goes to wdata[8k+7:8k].
REQ-022 Acceptance of byte 3 SHALL move LOAD->WRITE; in WRITE, we=1 for exactly one cycle, waddr=current word count, and wdata=the assembled word.
REQ-023 WRITE SHALL increment the word count; if the written word was number len-1 -> DONE, else -> LOAD.
REQ-024 Latency: byte 3 accepted at edge k gives we=1 in cycle k..k+1, and byte_ready=1 again from edge k+1 (or done=1 from edge k+1 on the last word).
REQ-025 byte_valid while byte_ready=0 SHALL be ignored; no byte is consumed or lost from the source.
REQ-026 we SHALL be 0 in every state other than WRITE; waddr and wdata SHALL hold their last values otherwise.
REQ-027 busy SHALL be 1 in LOAD and WRITE; start in those states SHALL be ignored.
REQ-028 done SHALL be 1 only in DONE; core_rst SHALL be 1 only in DONE.
REQ-029 DONE with a valid start SHALL restart the load (REQ-018): done and core_rst drop to 0 the cycle LOAD is entered.
REQ-030 A load with len=DEPTH SHALL write waddr 0..DEPTH-1 without counter wrap, then reach DONE.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE with byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, core_rst=0, and counters=0.
REQ-032 rst=0 during LOAD or WRITE SHALL discard any partial word and suppress any pending write; the core stays in reset.
REQ-033 After rst rises, the block SHALL stay in IDLE until a valid start.

Verification
REQ-034 Reset then start, len=2, bytes 33,E2,62,00,23,24,B6,00 -> we pulses with (waddr 0, 0062E233) and (waddr 1, 00B62423); done=1 and core_rst=1 from the cycle after the second write.
REQ-035 len=1 with byte_valid toggling 1,0,1,0... -> exactly 4 bytes accepted, one write, and byte_ready=0 during WRITE.
REQ-036 start with len=0, then len=DEPTH+1 -> err=1, we never asserts, and state remains IDLE; a following valid start clears err.
REQ-037 rst=0 after 6 of 8 bytes with len=2 -> one write only (waddr 0); all outputs at reset values and no second write.
REQ-038 len=DEPTH full image -> DEPTH writes at waddr 0..DEPTH-1 in order, then done=1.
REQ-039 In DONE, start with len=1 -> core_rst and done fall to 0 the next cycle, and a new word is written at waddr 0.
